// File: rtl/ctrl_raiz.sv
// ctrl_raiz: sequencer for a digit-by-digit restoring square-root unit.
// Build option RAIZ_WDOG_EN adds a Z/ITER cross-check in CHECK and the ERRS state.
//
// state | meaning
// IDLE  | waiting for START
// LOAD  | LD strobe, radicand in, ITER cleared
// SHIFT | SH strobe, next bit pair enters the remainder
// TEST  | trial remainder sign sampled, ACPT/REJ issued on exit
// CHECK | counter terminal flag decides loop or finish
// FIN   | DONE pulse, root and remainder valid
// ERRS  | (RAIZ_WDOG_EN only) Z disagreed with ITER; parked with ERR=1
module ctrl_raiz #(
  parameter int N_ITER = 8,
  parameter int IW     = 5
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic          ABORT,
  input  logic          Z,
  input  logic          R_NEG,
  output logic          LD,
  output logic          SH,
  output logic          ACPT,
  output logic          REJ,
  output logic          BUSY,
  output logic          DONE,
  output logic [IW-1:0] ITER,
  output logic          ERR
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_TEST  = 3'd3,
    S_CHECK = 3'd4,
    S_FIN   = 3'd5
`ifdef RAIZ_WDOG_EN
    , S_ERRS = 3'd6
`endif
  } state_t;

  localparam logic [IW-1:0] ITER_N   = IW'(N_ITER);
  localparam logic [IW-1:0] ITER_MAX = {IW{1'b1}};

  state_t          state_q, state_d;
  logic            ld_q, ld_d, sh_q, sh_d, acpt_q, acpt_d, rej_q, rej_d;
  logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [IW-1:0]   iter_q, iter_d;

`ifdef RAIZ_WDOG_EN
  logic z_bad;
  assign z_bad = (!Z && (iter_q >= ITER_N)) || (Z && (iter_q < ITER_N));
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (START) state_d = S_LOAD;
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: state_d = S_TEST;
      S_TEST:  state_d = S_CHECK;
      S_CHECK: begin
`ifdef RAIZ_WDOG_EN
        if (z_bad)  state_d = S_ERRS;
        else if (Z) state_d = S_FIN;
        else        state_d = S_SHIFT;
`else
        state_d = Z ? S_FIN : S_SHIFT;
`endif
      end
      S_FIN:   state_d = S_IDLE;
`ifdef RAIZ_WDOG_EN
      S_ERRS:  if (START) state_d = S_LOAD;
`endif
      default: state_d = S_IDLE;
    endcase
    // ABORT overrides every transition out of a non-idle state
    if (ABORT && (state_q != S_IDLE)) state_d = S_IDLE;

    // Outputs are decoded from the next state so they line up with it
    ld_d   = (state_d == S_LOAD);
    sh_d   = (state_d == S_SHIFT);
    acpt_d = (state_q == S_TEST) && (state_d == S_CHECK) && !R_NEG;
    rej_d  = (state_q == S_TEST) && (state_d == S_CHECK) &&  R_NEG;
    done_d = (state_d == S_FIN);
    busy_d = (state_d == S_LOAD) || (state_d == S_SHIFT) || (state_d == S_TEST) ||
             (state_d == S_CHECK) || (state_d == S_FIN);

    iter_d = iter_q;
    if (state_d == S_LOAD) iter_d = '0;
    else if ((state_d == S_SHIFT) && (iter_q != ITER_MAX)) iter_d = iter_q + IW'(1);

`ifdef RAIZ_WDOG_EN
    err_d = err_q;
    if (state_d == S_LOAD)      err_d = 1'b0;
    else if (state_d == S_ERRS) err_d = 1'b1;
`else
    err_d = 1'b0;
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      ld_q    <= 1'b0;
      sh_q    <= 1'b0;
      acpt_q  <= 1'b0;
      rej_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      sh_q    <= sh_d;
      acpt_q  <= acpt_d;
      rej_q   <= rej_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      iter_q  <= iter_d;
    end
  end

  assign LD   = ld_q;
  assign SH   = sh_q;
  assign ACPT = acpt_q;
  assign REJ  = rej_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign ITER = iter_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_ctrl_raiz.sv
// tb_ctrl_raiz: directed bench for ctrl_raiz with counter and square-root datapath models.
// ACPT/REJ expectations are queued when a run is launched and popped as strobes appear.
module tb_ctrl_raiz;

  localparam int N  = 8;
  localparam int IW = 5;

  logic          CLK = 1'b0;
  logic          RST_N, START, ABORT, Z, R_NEG;
  logic          LD, SH, ACPT, REJ, BUSY, DONE, ERR;
  logic [IW-1:0] ITER;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  // environment model state
  int   cnt;
  logic z_q;
  bit   hold_z0 = 1'b0;
  bit   dp_mode = 1'b0;
  logic alt_bit;
  logic [15:0] rad, rad_in;
  int   rem, root, trial, rem_n;

  ctrl_raiz #(.N_ITER(N), .IW(IW)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT), .Z(Z), .R_NEG(R_NEG),
    .LD(LD), .SH(SH), .ACPT(ACPT), .REJ(REJ), .BUSY(BUSY), .DONE(DONE),
    .ITER(ITER), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  assign Z     = z_q;
  assign R_NEG = dp_mode ? (trial < 0) : alt_bit;
  always_comb rem_n = (rem << 2) | int'(rad[15:14]);

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= 0; z_q <= 1'b0; alt_bit <= 1'b0;
      rad <= '0; rem <= 0; root <= 0; trial <= 0;
    end else if (LD) begin
      cnt <= N; z_q <= 1'b0; alt_bit <= 1'b0;
      rad <= rad_in; rem <= 0; root <= 0; trial <= 0;
    end else begin
      if (SH) begin
        cnt   <= cnt - 1;
        z_q   <= hold_z0 ? 1'b0 : (cnt == 1);
        rem   <= rem_n;
        rad   <= rad << 2;
        trial <= rem_n - ((root << 2) | 1);
      end
      if (ACPT) begin
        rem <= trial; root <= (root << 1) | 1; alt_bit <= ~alt_bit;
      end
      if (REJ) begin
        root <= root << 1; alt_bit <= ~alt_bit;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: each ACPT/REJ pulse pops one expected root bit (1 = ACPT)
  always @(negedge CLK) begin
    if (RST_N === 1'b1 && (ACPT === 1'b1 || REJ === 1'b1)) begin
      if (exp_q.size() == 0) chk("sb_unexpected_strobe", 32'd1, 32'd0);
      else chk("sb_acpt_rej", {30'd0, ACPT, REJ}, exp_q[0] ? 32'd2 : 32'd1);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
  end

  // {LD,SH,ACPT|REJ,BUSY,DONE} for cycle c of a run (c=1 is the LOAD cycle)
  function automatic logic [4:0] exp_vec(input int c, input bit fin);
    if (c == 1)                return 5'b10010;
    if (fin && c == 3*N + 2)   return 5'b00011;
    if (fin && c >  3*N + 2)   return 5'b00000;
    if ((c - 2) % 3 == 0)      return 5'b01010;
    if ((c - 1) % 3 == 0)      return 5'b00110;
    return 5'b00010;
  endfunction

  function automatic int exp_iter(input int c, input bit fin);
    int v;
    if (c <= 1) return 0;
    v = (c - 2) / 3 + 1;
    if (fin && v > N) v = N;
    if (v > 31) v = 31;
    return v;
  endfunction

  function automatic logic [4:0] obs_vec();
    return {LD, SH, ACPT | REJ, BUSY, DONE};
  endfunction

  task automatic push_alt(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back((i % 2) == 0);
  endtask

  // Called at a negedge; launches a run and checks ncyc cycles of it
  task automatic run_check(input int ncyc, input bit fin, input int abort_at, input bit abort_with_start);
    START = 1'b1;
    ABORT = abort_with_start;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge CLK);
      if (c == 1) begin START = 1'b0; ABORT = 1'b0; end
      chk($sformatf("run_vec_c%0d", c), obs_vec(), exp_vec(c, fin));
      chk($sformatf("run_iter_c%0d", c), ITER, exp_iter(c, fin));
      chk($sformatf("run_err_c%0d", c), ERR, 0);
      if (c == abort_at) ABORT = 1'b1;
    end
    if (abort_at > 0) begin
      @(negedge CLK);
      ABORT = 1'b0;
      chk("abort_idle_vec", obs_vec(), 0);
      chk("abort_iter_hold", ITER, exp_iter(abort_at, fin));
      for (int k = 0; k < 3; k++) begin
        @(negedge CLK);
        chk("abort_no_done", {DONE, BUSY}, 0);
      end
    end
  endtask

  initial begin
    bit seen;
    RST_N = 1'b0; START = 1'b1; ABORT = 1'b0; rad_in = 16'd0;
    #3;
    chk("reset_vec", obs_vec(), 0);
    chk("reset_iter", ITER, 0);
    chk("reset_err", ERR, 0);
    @(negedge CLK); @(negedge CLK);
    RST_N = 1'b1;

    // two back-to-back runs with START held, then toggled during the second
    push_alt(2 * N);
    for (int c = 1; c <= 54; c++) begin
      int p;
      @(negedge CLK);
      p = (c >= 28) ? c - 27 : c;
      chk($sformatf("b2b_vec_c%0d", c), obs_vec(), exp_vec(p, 1'b1));
      chk($sformatf("b2b_iter_c%0d", c), ITER, exp_iter(p, 1'b1));
      chk($sformatf("b2b_err_c%0d", c), ERR, 0);
      if (c >= 29 && c <= 50) START = c[0];
      else if (c > 50)        START = 1'b0;
    end
    chk("b2b_sb_drained", exp_q.size(), 0);

    // sqrt(200): root 14 = 0000_1110, remainder 4
    dp_mode = 1'b1; rad_in = 16'd200;
    for (int i = 7; i >= 0; i--) exp_q.push_back(((14 >> i) & 1) == 1);
    START = 1'b1;
    seen = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge CLK);
      if (c == 1) START = 1'b0;
      if (DONE === 1'b1) begin
        seen = 1'b1;
        chk("sqrt_latency", c, 3*N + 2);
        chk("sqrt_root", root, 14);
        chk("sqrt_rem", rem, 4);
        chk("sqrt_iter", ITER, N);
      end
    end
    chk("sqrt_done_seen", seen, 1);
    chk("sqrt_sb_drained", exp_q.size(), 0);
    dp_mode = 1'b0;
    @(negedge CLK);

    // ABORT in the TEST after the 3rd SH, then START+ABORT in IDLE starts a full run
    push_alt(2);
    run_check(9, 1'b1, 9, 1'b0);
    push_alt(N);
    run_check(27, 1'b1, 0, 1'b1);
    chk("abort_sb_drained", exp_q.size(), 0);

    // asynchronous reset in cycle 10 (a strobe cycle)
    push_alt(3);
    run_check(10, 1'b1, 0, 1'b0);
    #2 RST_N = 1'b0;
    #1;
    chk("midrst_vec", obs_vec(), 0);
    chk("midrst_iter", ITER, 0);
    chk("midrst_err", ERR, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("midrst_idle", obs_vec(), 0);
    chk("midrst_sb_drained", exp_q.size(), 0);

    // counter stuck with Z=0
    hold_z0 = 1'b1;
`ifdef RAIZ_WDOG_EN
    push_alt(N);
    run_check(3*N + 1, 1'b1, 0, 1'b0);
    @(negedge CLK);
    chk("wdog_errs_vec", obs_vec(), 0);
    chk("wdog_err_set", ERR, 1);
    @(negedge CLK);
    chk("wdog_errs_hold", {obs_vec(), ERR}, 1);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    chk("wdog_restart_vec", obs_vec(), 5'b10010);
    chk("wdog_err_clr", ERR, 0);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    chk("wdog_abort_idle", obs_vec(), 0);
`else
    push_alt(N + 1);
    run_check(30, 1'b0, 30, 1'b0);
`endif
    hold_z0 = 1'b0;
    chk("wdog_sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
